// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operand width, op encodings, FSM states and divide-by-zero quotient.
package mul_div_unit_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [WIDTH-1:0] DIV_BY_ZERO_Q = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        OP_MULLO = 2'b00,
        OP_MULHI = 2'b01,
        OP_DIVQ  = 2'b10,
        OP_DIVR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_e;

endpackage

// File: rtl/mul_div_datapath.sv
// One combinational iteration step: shift-add multiply or restoring divide.
// Ports: div (op class), hi/lo/m (current state), hi_n/lo_n (next state).
module mul_div_datapath
    import mul_div_unit_pkg::*;
(
    input  logic             div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] hi_n,
    output logic [WIDTH-1:0] lo_n
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        addend = lo[0] ? m : '0;
        sum    = {1'b0, hi} + {1'b0, addend};
        // Shifted partial remainder; its low byte minus the
        // divisor is exact whenever the trial is non-negative.
        rem    = {hi, lo[WIDTH-1]};
        ge     = rem >= {1'b0, m};
        diff   = rem[WIDTH-1:0] - m;
        hi_n   = '0;
        lo_n   = '0;
        unique case (1'b1)
            div: begin
                hi_n = ge ? diff : rem[WIDTH-1:0];
                lo_n = {lo[WIDTH-2:0], ge};
            end
            !div: begin
                hi_n = sum[WIDTH:1];
                lo_n = {sum[0], lo[WIDTH-1:1]};
            end
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit fed by the register file.
// Ports: CLK, RESET, START, OP, DATA1, DATA2 in; RESULT, BUSY, DONE, DIVZERO out.
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIVZERO
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state;
    state_e           state_n;
    op_e              op_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;
    logic             dz_start;
    logic             last;

    // Divide-by-zero skips iteration entirely.
    assign dz_start = OP[1] && (DATA2 == '0);
    assign last     = (cnt == CNT_LAST);

    mul_div_datapath u_dp (
        .div  (op_q[1]),
        .hi   (hi),
        .lo   (lo),
        .m    (m),
        .hi_n (hi_n),
        .lo_n (lo_n)
    );

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_n;
    end

    // FIN lasts until DONE has been shown for one cycle; the
    // divide-by-zero path enters FIN with DONE still low.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (START) state_n = dz_start ? FIN : RUN;
            RUN:     if (last)  state_n = FIN;
            FIN:     if (DONE)  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            op_q    <= OP_MULLO;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            m       <= '0;
            RESULT  <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            DIVZERO <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (START) begin
                        op_q    <= op_e'(OP);
                        cnt     <= '0;
                        hi      <= '0;
                        lo      <= OP[1] ? DATA1 : DATA2;
                        m       <= OP[1] ? DATA2 : DATA1;
                        BUSY    <= !dz_start;
                        DIVZERO <= dz_start;
                    end
                end
                RUN: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt + CNT_ONE;
                    if (last) begin
                        BUSY   <= 1'b0;
                        DONE   <= 1'b1;
                        RESULT <= op_q[0] ? hi_n : lo_n;
                    end
                end
                FIN: begin
                    if (!DONE) begin
                        // Remainder of x/0 is the untouched dividend.
                        DONE   <= 1'b1;
                        RESULT <= op_q[0] ? lo : DIV_BY_ZERO_Q;
                    end else begin
                        DONE <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: arithmetic reference model
// compared every cycle, plus directed literal cases.
module tb_mul_div_unit;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic [1:0] OP = 2'b00;
    logic [7:0] DATA1 = 8'd0;
    logic [7:0] DATA2 = 8'd0;
    logic [7:0] RESULT;
    logic       BUSY;
    logic       DONE;
    logic       DIVZERO;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    // Reference model state
    int m_res    = 0;
    bit m_busy   = 0;
    bit m_done   = 0;
    bit m_dz     = 0;
    bit inflight = 0;
    int pend     = 0;
    int cyc      = 0;
    int done_at  = 0;

    mul_div_unit dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .START   (START),
        .OP      (OP),
        .DATA1   (DATA1),
        .DATA2   (DATA2),
        .RESULT  (RESULT),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .DIVZERO (DIVZERO)
    );

    always #5 CLK = ~CLK;

    function automatic void chk(string nm, int act, int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endfunction

    function automatic int ref_op(int op, int a, int b);
        case (op)
            0: return (a * b) % 256;
            1: return (a * b) / 256;
            2: return (b == 0) ? 255 : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Timeline model: START at edge k completes at k+8
    // (or k+1 for x/0); DONE drops on the following edge.
    always @(posedge CLK) begin
        cyc++;
        if (RESET) begin
            m_res = 0; m_busy = 0; m_done = 0;
            m_dz = 0; inflight = 0;
        end else if (inflight) begin
            if (cyc == done_at) begin
                m_done = 1; m_busy = 0;
                m_res = pend; inflight = 0;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (START) begin
            pend = ref_op(int'(OP), int'(DATA1), int'(DATA2));
            m_dz = OP[1] && (DATA2 == 8'd0);
            inflight = 1;
            m_busy = !m_dz;
            done_at = cyc + (m_dz ? 1 : 8);
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("cyc_result", int'(RESULT), m_res);
            chk("cyc_busy", int'(BUSY), int'(m_busy));
            chk("cyc_done", int'(DONE), int'(m_done));
            chk("cyc_divzero", int'(DIVZERO), int'(m_dz));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic run_op(input int op, input int a,
                          input int b, input int exp_res,
                          input int exp_dz, input int exp_lat);
        int n = 0;
        int nb = 0;
        START = 1'b1;
        OP = 2'(op);
        DATA1 = 8'(a);
        DATA2 = 8'(b);
        tick();
        START = 1'b0;
        while (!DONE && n < 20) begin
            if (BUSY) nb++;
            tick();
            n++;
        end
        chk("lit_latency", n, exp_lat);
        chk("lit_busy_cycles", nb, exp_lat == 1 ? 0 : 8);
        chk("lit_result", int'(RESULT), exp_res);
        chk("lit_divzero", int'(DIVZERO), exp_dz);
        tick();
    endtask

    initial begin
        int dn;
        tick();
        chk_en = 1;
        chk("rst_result", int'(RESULT), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_divzero", int'(DIVZERO), 0);
        RESET = 1'b0;
        tick();

        run_op(0, 13, 11, 8'h8F, 0, 8);
        run_op(1, 200, 200, 8'h9C, 0, 8);
        run_op(0, 200, 200, 8'h40, 0, 8);
        run_op(2, 200, 7, 28, 0, 8);
        run_op(3, 200, 7, 4, 0, 8);
        run_op(2, 55, 0, 8'hFF, 1, 1);
        run_op(3, 55, 0, 55, 1, 1);
        run_op(1, 255, 255, 8'hFE, 0, 8);
        run_op(2, 5, 9, 0, 0, 8);

        // Second START in RUN is ignored
        START = 1'b1; OP = 2'd0;
        DATA1 = 8'd9; DATA2 = 8'd10;
        tick();
        START = 1'b0;
        tick(); tick();
        START = 1'b1; OP = 2'd2;
        DATA1 = 8'd100; DATA2 = 8'd3;
        tick();
        START = 1'b0;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            if (DONE) begin
                dn++;
                chk("ign_result", int'(RESULT), 90);
            end
            tick();
        end
        chk("ign_done_count", dn, 1);
        tick();

        // Reset mid-operation
        START = 1'b1; OP = 2'd1;
        DATA1 = 8'd250; DATA2 = 8'd250;
        tick();
        START = 1'b0;
        tick(); tick(); tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("abort_result", int'(RESULT), 0);
        chk("abort_busy", int'(BUSY), 0);
        chk("abort_done", int'(DONE), 0);
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            if (DONE) dn++;
            tick();
        end
        chk("abort_no_done", dn, 0);
        run_op(0, 6, 7, 42, 0, 8);

        // Randomised traffic, checked by the model
        for (int i = 0; i < 600; i++) begin
            START = ($urandom_range(0, 2) == 0);
            OP    = 2'($urandom_range(0, 3));
            DATA1 = 8'($urandom_range(0, 255));
            DATA2 = ($urandom_range(0, 5) == 0) ?
                    8'd0 : 8'($urandom_range(0, 255));
            RESET = ($urandom_range(0, 79) == 0);
            tick();
        end
        START = 1'b0;
        RESET = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
